mux8_rr_arbiter: RTL and testbench



---
 rtl/mux8_rr_arbiter_pkg.sv | 12 +
 rtl/mux8.sv | 10 +
 rtl/mux8_rr_arbiter_rr_pick.sv | 33 +++
 rtl/mux8_rr_arbiter.sv | 104 ++++++++++
 tb/tb_mux8_rr_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [2:0] LAST_RST      = 3'd7;
    localparam int         BURST_LEN_DEF = 4;

endpackage

// File: rtl/mux8.sv
// Existing 8:1 serial line multiplexer.
module mux8 (
    input  logic [7:0] d_i,
    input  logic [2:0] sel_i,
    output logic       y_o
);

    assign y_o = d_i[sel_i];

endmodule

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Rotated priority encoder: first requester after `last`, wrapping to `last`.
module rr_pick (
    input  logic [7:0] req_i,
    input  logic [2:0] last_i,
    output logic [2:0] winner_o,
    output logic       any_o
);

    logic [2:0] start;
    logic [7:0] rot;
    logic [2:0] off;

    assign start = last_i + 3'd1;
    assign any_o = |req_i;

    // rot[0] is the highest-priority requester
    always_comb begin
        rot = '0;
        for (int i = 0; i < 8; i++) begin
            rot[i] = req_i[3'(i) + start];
        end
    end

    always_comb begin
        off = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
    end

    assign winner_o = start + off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter sharing one 8:1 serial mux among 8 requesters.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CNT_W     = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] Req,
    input  logic [7:0] D,
    output logic [7:0] Grant,
    output logic [2:0] Sel,
    output logic       Valid,
    output logic       Dout,
    output logic       Busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       last_q, last_d;
    logic [7:0]       grant_q, grant_d;

    logic [2:0] winner;
    logic       any;
    logic       burst_end;
    logic       mux_y;

    rr_pick u_pick (
        .req_i    (Req),
        .last_i   (last_q),
        .winner_o (winner),
        .any_o    (any)
    );

    mux8 u_mux (
        .d_i   (D),
        .sel_i (sel_q),
        .y_o   (mux_y)
    );

    assign burst_end = (cnt_q == CNT_MAX) || !Req[sel_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                    sel_d   = winner;
                    last_d  = winner;
                    grant_d = 8'b1 << winner;
                end
            end
            GRANT: begin
                if (!burst_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (any) begin
                    // back-to-back handover, no idle bubble
                    cnt_d   = '0;
                    sel_d   = winner;
                    last_d  = winner;
                    grant_d = 8'b1 << winner;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= LAST_RST;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign Grant = grant_q;
    assign Sel   = sel_q;
    assign Valid = (state_q == GRANT);
    assign Busy  = (state_q == GRANT);
    assign Dout  = mux_y & Valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter at BURST_LEN 4 and BURST_LEN 1.
module tb_mux8_rr_arbiter;

    logic       Clock;
    logic       Resetn;
    logic [7:0] Req;
    logic [7:0] D;

    logic [7:0] g4, g1;
    logic [2:0] s4, s1;
    logic       v4, v1, o4, o1, b4, b1;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    int m_busy[2];
    int m_cnt[2];
    int m_sel[2];
    int m_last[2];
    int m_bl[2] = '{4, 1};

    mux8_rr_arbiter #(.BURST_LEN(4), .CNT_W(4)) dut4 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Req    (Req),
        .D      (D),
        .Grant  (g4),
        .Sel    (s4),
        .Valid  (v4),
        .Dout   (o4),
        .Busy   (b4)
    );

    mux8_rr_arbiter #(.BURST_LEN(1), .CNT_W(4)) dut1 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Req    (Req),
        .D      (D),
        .Grant  (g1),
        .Sel    (s1),
        .Valid  (v1),
        .Dout   (o1),
        .Busy   (b1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0;
            m_cnt[k]  = 0;
            m_sel[k]  = 0;
            m_last[k] = 7;
        end
    endtask

    task automatic model_load(input int k, input logic [7:0] r);
        int w;
        w = -1;
        for (int i = 1; i <= 8; i++) begin
            int j;
            j = (m_last[k] + i) % 8;
            if (w < 0 && r[j]) w = j;
        end
        m_sel[k]  = w;
        m_last[k] = w;
        m_cnt[k]  = 0;
        m_busy[k] = 1;
    endtask

    task automatic model_edge(input int k, input logic [7:0] r);
        if (m_busy[k] == 0) begin
            if (r != 0) model_load(k, r);
        end else if (m_cnt[k] < m_bl[k] - 1 && r[m_sel[k]]) begin
            m_cnt[k]++;
        end else if (r != 0) begin
            model_load(k, r);
        end else begin
            m_busy[k] = 0;
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.grant = m_busy[k] != 0 ? 8'(1 << m_sel[k]) : 8'h00;
        e.sel   = 3'(m_sel[k]);
        e.valid = m_busy[k] != 0;
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t e, input logic [7:0] g,
                       input logic [2:0] s, input logic v, input logic b,
                       input logic o);
        chk({nm, ".grant"}, 32'(g), 32'(e.grant));
        chk({nm, ".sel"},   32'(s), 32'(e.sel));
        chk({nm, ".valid"}, 32'(v), 32'(e.valid));
        chk({nm, ".busy"},  32'(b), 32'(e.valid));
        chk({nm, ".dout"},  32'(o), 32'(D[e.sel] & e.valid));
    endtask

    task automatic step(input logic [7:0] r);
        exp_t e4, e1;
        @(negedge Clock);
        Resetn = 1'b1;
        Req    = r;
        D      = 8'($urandom);
        @(posedge Clock);
        for (int k = 0; k < 2; k++) begin
            model_edge(k, r);
            exp_q.push_back(model_out(k));
        end
        #1;
        e4 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        cmp("bl4", e4, g4, s4, v4, b4, o4);
        cmp("bl1", e1, g1, s1, v1, b1, o1);
    endtask

    initial begin
        Resetn = 1'b0;
        Req    = 8'h00;
        D      = 8'h00;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        chk("rst.grant", 32'(g4), 32'h0);
        chk("rst.sel",   32'(s4), 32'h0);
        chk("rst.valid", 32'(v4), 32'h0);
        chk("rst.busy",  32'(b4), 32'h0);

        repeat (5) step(8'h00);

        step(8'h01);
        chk("req01.first", 32'(g4), 32'h01);
        repeat (11) step(8'h01);

        repeat (16) step(8'h81);

        repeat (2) step(8'h00);
        step(8'h24);
        chk("early.g2", 32'(g4), 32'h04);
        step(8'h20);
        chk("early.g5", 32'(g4), 32'h20);
        repeat (5) step(8'h20);

        repeat (12) step(8'hFF);

        repeat (2) step(8'h00);
        step(8'h10);
        step(8'h10);
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst.grant", 32'(g4), 32'h0);
        chk("arst.valid", 32'(v4), 32'h0);
        chk("arst.dout",  32'(o4), 32'h0);
        model_reset();
        step(8'h10);
        chk("arst.regrant", 32'(g4), 32'h10);
        repeat (3) step(8'h10);

        repeat (3) step(8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
